// File: rtl/clk_gen_pkg.sv
// Shared types and defaults for the 3.58 MHz slot-clock generator.
package clk_gen_pkg;

    typedef enum logic [1:0] {ST_LOW, ST_HIGH, ST_HOLD} clk_gen_state_t;

    localparam int CLK_GEN_ACC_W      = 24;
    localparam int CLK_GEN_INC_NORMAL = 1112126;
    localparam int CLK_GEN_INC_FAST   = 2224252;

    // Per-clock increment for an NCO whose every carry marks one half-period
    // of f_out_hz, rounded to nearest.
    function automatic longint calc_inc(longint f_out_hz, longint f_clk_hz, int acc_w);
        longint num;
        num = (longint'(1) << acc_w) * 2 * f_out_hz;
        return (num + f_clk_hz / 2) / f_clk_hz;
    endfunction

endpackage

// File: rtl/clk_gen_nco.sv
// Fractional phase accumulator; each carry marks one half-period boundary.
module clk_gen_nco
    import clk_gen_pkg::*;
#(
    parameter int ACC_W = CLK_GEN_ACC_W
) (
    input  logic             CLK,
    input  logic             RESET_n,
    input  logic [ACC_W-1:0] inc,
    input  logic             advance,
    input  logic             clear,
    output logic             carry
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    assign sum   = {1'b0, acc} + {1'b0, inc};
    assign carry = advance & sum[ACC_W];

    // Phase register: parks at zero when cleared, wraps modulo 2^ACC_W otherwise.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (advance) begin
            acc <= sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/clk_gen_358.sv
// Cartridge-side 3.58 MHz slot clock generator with normal/fast rate and
// one-cycle rising-edge enable. Optional build macro CLK_GEN_WAIT_EN adds the
// WAIT_n input that stretches the high phase.
module clk_gen_358
    import clk_gen_pkg::*;
#(
    parameter int ACC_W      = CLK_GEN_ACC_W,
    parameter int INC_NORMAL = CLK_GEN_INC_NORMAL,
    parameter int INC_FAST   = CLK_GEN_INC_FAST
) (
    input  logic CLK,
    input  logic RESET_n,
    input  logic RUN,
    input  logic SPEED_REQ,
`ifdef CLK_GEN_WAIT_EN
    input  logic WAIT_n,
`endif
    output logic SPEED_ACK,
    output logic CLK_3_58M,
    output logic CLK_3_58M_EN
);

    clk_gen_state_t   state;
    logic [ACC_W-1:0] inc;
    logic             advance;
    logic             clear;
    logic             carry;
    logic             wait_hold;

    // The rate is latched into SPEED_ACK only at falling edges, so inc never
    // changes in the middle of a phase.
    assign inc     = SPEED_ACK ? ACC_W'(INC_FAST) : ACC_W'(INC_NORMAL);
    assign advance = (state != ST_LOW) || RUN;
    assign clear   = (state == ST_LOW) && !RUN;

`ifdef CLK_GEN_WAIT_EN
    assign wait_hold = !WAIT_n;
`else
    assign wait_hold = 1'b0;
`endif

    clk_gen_nco #(
        .ACC_W   (ACC_W)
    ) u_nco (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .inc     (inc),
        .advance (advance),
        .clear   (clear),
        .carry   (carry)
    );

    // Phase FSM: each carry toggles the output; a pending wait keeps it high.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state        <= ST_LOW;
            CLK_3_58M    <= 1'b0;
            CLK_3_58M_EN <= 1'b0;
            SPEED_ACK    <= 1'b0;
        end else begin
            CLK_3_58M_EN <= 1'b0;
            case (state)
                ST_LOW: begin
                    if (carry) begin
                        state        <= ST_HIGH;
                        CLK_3_58M    <= 1'b1;
                        CLK_3_58M_EN <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (carry) begin
                        if (wait_hold) begin
                            state <= ST_HOLD;
                        end else begin
                            state     <= ST_LOW;
                            CLK_3_58M <= 1'b0;
                            SPEED_ACK <= SPEED_REQ;
                        end
                    end
                end
                ST_HOLD: begin
                    if (carry && !wait_hold) begin
                        state     <= ST_LOW;
                        CLK_3_58M <= 1'b0;
                        SPEED_ACK <= SPEED_REQ;
                    end
                end
                default: begin
                    state     <= ST_LOW;
                    CLK_3_58M <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_gen_358.sv
// Self-checking bench for clk_gen_358: per-cycle reference model, a table of
// run/rate scenarios, and hand-written multi-cycle corner sequences.
module tb_clk_gen_358;

    localparam longint MOD   = 64'd16777216;
    localparam longint INC_N = 64'd1112126;
    localparam longint INC_F = 64'd2224252;

    logic CLK = 1'b0;
    logic RESET_n = 1'b0;
    logic RUN = 1'b0;
    logic SPEED_REQ = 1'b0;
    logic WAIT_n = 1'b1;
    logic SPEED_ACK;
    logic CLK_3_58M;
    logic CLK_3_58M_EN;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    longint m_acc = 0;
    bit     m_out = 1'b0;
    bit     m_en  = 1'b0;
    bit     m_ack = 1'b0;

    // phase measurement
    logic prev_out = 1'b0;
    int   cur_len = 0;
    int   done_len = 0;
    logic done_level = 1'b0;
    bit   phase_done = 1'b0;
    int   en_cnt = 0;

    always #5 CLK = ~CLK;

    clk_gen_358 dut (
        .CLK          (CLK),
        .RESET_n      (RESET_n),
        .RUN          (RUN),
        .SPEED_REQ    (SPEED_REQ),
`ifdef CLK_GEN_WAIT_EN
        .WAIT_n       (WAIT_n),
`endif
        .SPEED_ACK    (SPEED_ACK),
        .CLK_3_58M    (CLK_3_58M),
        .CLK_3_58M_EN (CLK_3_58M_EN)
    );

    typedef struct {
        bit run;
        bit req;
        int cycles;
        int en_min;
        int en_max;
        bit ack_end;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic model_reset();
        m_acc = 0;
        m_out = 1'b0;
        m_en  = 1'b0;
        m_ack = 1'b0;
    endtask

    // One CLK edge of the reference: phase accumulates at the active rate,
    // every wrap is a half-period boundary; a falling edge is deferred while
    // WAIT_n is low and latches the requested rate.
    task automatic model_edge();
        longint total;
        if (!RESET_n) begin
            model_reset();
            return;
        end
        m_en = 1'b0;
        if (!m_out && !RUN) begin
            m_acc = 0;
            return;
        end
        total = m_acc + (m_ack ? INC_F : INC_N);
        if (total >= MOD) begin
            m_acc = total - MOD;
            if (!m_out) begin
                m_out = 1'b1;
                m_en  = 1'b1;
            end else if (WAIT_n) begin
                m_out = 1'b0;
                m_ack = SPEED_REQ;
            end
        end else begin
            m_acc = total;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        chk("clk_out", 64'(CLK_3_58M), 64'(m_out));
        chk("clk_en", 64'(CLK_3_58M_EN), 64'(m_en));
        chk("speed_ack", 64'(SPEED_ACK), 64'(m_ack));
        phase_done = 1'b0;
        if (CLK_3_58M === prev_out) begin
            cur_len++;
        end else begin
            done_len   = cur_len;
            done_level = prev_out;
            phase_done = 1'b1;
            cur_len    = 1;
            prev_out   = CLK_3_58M;
        end
        if (CLK_3_58M_EN === 1'b1) en_cnt++;
    endtask

    task automatic do_reset();
        RUN       = 1'b0;
        SPEED_REQ = 1'b0;
        WAIT_n    = 1'b1;
        RESET_n   = 1'b0;
        model_reset();
        prev_out = 1'b0;
        cur_len  = 0;
        repeat (3) step();
        RESET_n = 1'b1;
        en_cnt = 0;
    endtask

    task automatic wait_en(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (CLK_3_58M_EN !== 1'b1 && n < limit);
        chk("en_seen", 64'(CLK_3_58M_EN), 64'd1);
    endtask

    task automatic wait_fall(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!(phase_done && done_level == 1'b1) && n < limit);
        chk("fall_seen", 64'(phase_done && done_level == 1'b1), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   n;
        int   phases;

        vecs[0] = '{run: 1'b0, req: 1'b0, cycles: 200,  en_min: 0,   en_max: 0,   ack_end: 1'b0};
        vecs[1] = '{run: 1'b1, req: 1'b0, cycles: 3018, en_min: 99,  en_max: 101, ack_end: 1'b0};
        vecs[2] = '{run: 1'b1, req: 1'b1, cycles: 3018, en_min: 196, en_max: 201, ack_end: 1'b1};
        vecs[3] = '{run: 1'b1, req: 1'b1, cycles: 20,   en_min: 1,   en_max: 1,   ack_end: 1'b0};
        vecs[4] = '{run: 1'b1, req: 1'b0, cycles: 15,   en_min: 0,   en_max: 0,   ack_end: 1'b0};

        // reset state
        do_reset();
        chk("rst_clk", 64'(CLK_3_58M), 64'd0);
        chk("rst_en", 64'(CLK_3_58M_EN), 64'd0);
        chk("rst_ack", 64'(SPEED_ACK), 64'd0);
        chk("rst_acc", 64'(dut.u_nco.acc), 64'd0);

        // table of run/rate scenarios, each from reset
        for (int i = 0; i < 5; i++) begin
            do_reset();
            RUN       = vecs[i].run;
            SPEED_REQ = vecs[i].req;
            repeat (vecs[i].cycles) step();
            chk_range($sformatf("vec%0d_en_count", i), en_cnt, vecs[i].en_min, vecs[i].en_max);
            chk($sformatf("vec%0d_ack", i), 64'(SPEED_ACK), 64'(vecs[i].ack_end));
        end

        // long normal-rate run: EN count and every half-period 15/16
        do_reset();
        RUN = 1'b1;
        phases = 0;
        repeat (40000) begin
            step();
            if (phase_done) begin
                phases++;
                if (phases > 1) chk_range("normal_phase_len", done_len, 15, 16);
            end
        end
        chk_range("normal_en_count", en_cnt, 1325, 1327);
        chk("normal_ack", 64'(SPEED_ACK), 64'd0);

        // rate request mid-HIGH
        do_reset();
        RUN = 1'b1;
        wait_en(40, n);
        repeat (2) step();
        SPEED_REQ = 1'b1;
        wait_fall(40, n);
        chk_range("req_high_len", done_len, 15, 16);
        chk("ack_at_fall", 64'(SPEED_ACK), 64'd1);
        phases = 0;
        n = 0;
        while (phases < 6 && n < 200) begin
            step();
            n++;
            if (phase_done) begin
                phases++;
                chk_range("fast_phase_len", done_len, 7, 8);
            end
        end
        chk("fast_phases_seen", 64'(phases), 64'd6);

        // RUN drop during HIGH
        do_reset();
        RUN = 1'b1;
        wait_en(40, n);
        repeat (2) step();
        RUN = 1'b0;
        wait_fall(40, n);
        chk_range("drop_high_len", done_len, 15, 16);
        en_cnt = 0;
        repeat (100) step();
        chk("drop_no_en", 64'(en_cnt), 64'd0);
        chk("drop_clk_low", 64'(CLK_3_58M), 64'd0);
        chk("drop_acc_zero", 64'(dut.u_nco.acc), 64'd0);
        RUN = 1'b1;
        wait_en(40, n);
        chk_range("rerun_latency", n, 15, 16);

        // asynchronous reset mid-HIGH at fast rate
        do_reset();
        RUN = 1'b1;
        SPEED_REQ = 1'b1;
        n = 0;
        while (SPEED_ACK !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk("fast_reached", 64'(SPEED_ACK), 64'd1);
        wait_en(20, n);
        repeat (2) step();
        chk("pre_reset_high", 64'(CLK_3_58M), 64'd1);
        #2;
        RESET_n = 1'b0;
        #1;
        chk("async_rst_clk", 64'(CLK_3_58M), 64'd0);
        chk("async_rst_en", 64'(CLK_3_58M_EN), 64'd0);
        chk("async_rst_ack", 64'(SPEED_ACK), 64'd0);
        model_reset();
        prev_out = 1'b0;
        cur_len  = 0;
        repeat (2) step();
        RESET_n = 1'b1;
        wait_en(40, n);
        chk_range("post_reset_latency", n, 15, 16);

`ifdef CLK_GEN_WAIT_EN
        // wait stretch of the high phase
        do_reset();
        RUN = 1'b1;
        wait_en(40, n);
        WAIT_n = 1'b0;
        en_cnt = 0;
        repeat (40) step();
        chk("wait_no_en", 64'(en_cnt), 64'd0);
        chk("wait_still_high", 64'(CLK_3_58M), 64'd1);
        WAIT_n = 1'b1;
        wait_fall(20, n);
        chk_range("wait_release_fall", n, 1, 16);
        chk_range("wait_high_len", done_len, 41, 60);
`endif

        // randomized activity against the reference model
        do_reset();
        RUN = 1'b1;
        repeat (3000) begin
            if ($urandom_range(63) == 0) RUN = ~RUN;
            if ($urandom_range(49) == 0) SPEED_REQ = ~SPEED_REQ;
`ifdef CLK_GEN_WAIT_EN
            if ($urandom_range(31) == 0) WAIT_n = ~WAIT_n;
`endif
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
